// File: rtl/spart_rx_fifo.sv
// SPART receive path: 2-FF rxd synchronizer, divisor-driven oversample tick,
// frame receiver FSM (start / data / parity / stop bits) and a
// first-word-fall-through FIFO holding {frame_err, parity_err, data}.
//
// state  | meaning
// IDLE   | line idle, waiting for synchronized rxd low
// START  | validating the start bit at mid-bit
// DATA   | shifting in DATA_BITS data bits, LSB first
// PARITY | sampling and checking the parity bit
// STOP1  | sampling the first stop bit
// STOP2  | sampling the second stop bit (when stop2 was captured)
module spart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic [DIV_W-1:0]     divisor,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop2,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_frame_err,
    output logic                 rd_parity_err,
    output logic                 rda,
    output logic                 fifo_full,
    output logic                 overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t               state;
    logic                 rxd_s1, rxd_s2;
    logic [DIV_W-1:0]     div_cnt, div_reload;
    logic                 tick, start_det, smp, push, pop, wr_ok;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 frame_err, parity_err;
    logic                 cfg_par_en, cfg_par_odd, cfg_stop2;
    logic [EW-1:0]        push_entry, head;
    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;

    // Two-stage synchronizer for the asynchronous serial line, idle-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
        end else begin
            rxd_s1 <= rxd;
            rxd_s2 <= rxd_s1;
        end
    end

    assign div_reload = (divisor == '0) ? '0 : divisor - DIV_W'(1);
    assign tick       = (div_cnt == '0);
    assign start_det  = (state == S_IDLE) && !rxd_s2;

    // Oversample tick down-counter; realigned when a start edge is seen.
    always_ff @(posedge clk) begin
        if (rst)
            div_cnt <= '0;
        else if (start_det || tick)
            div_cnt <= div_reload;
        else
            div_cnt <= div_cnt - DIV_W'(1);
    end

    // Start bit is sampled half a bit in; every later bit one full bit after.
    always_comb begin
        smp = 1'b0;
        if (tick) begin
            if (state == S_START)
                smp = (tick_cnt == TW'(OVERSAMPLE/2 - 1));
            else
                smp = (tick_cnt == TW'(OVERSAMPLE - 1));
        end
    end

    assign push       = smp && ((state == S_STOP2) || (state == S_STOP1 && !cfg_stop2));
    assign push_entry = {frame_err | ~rxd_s2, parity_err, shift};

    // Frame receiver FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            cfg_par_en  <= 1'b0;
            cfg_par_odd <= 1'b0;
            cfg_stop2   <= 1'b0;
        end else begin
            if (state != S_IDLE && tick)
                tick_cnt <= smp ? '0 : tick_cnt + TW'(1);
            case (state)
                S_IDLE: begin
                    if (!rxd_s2) begin
                        state       <= S_START;
                        tick_cnt    <= '0;
                        bit_cnt     <= '0;
                        frame_err   <= 1'b0;
                        parity_err  <= 1'b0;
                        cfg_par_en  <= parity_en;
                        cfg_par_odd <= parity_odd;
                        cfg_stop2   <= stop2;
                    end
                end
                S_START: begin
                    if (smp)
                        state <= rxd_s2 ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (smp) begin
                        shift <= {rxd_s2, shift[DATA_BITS-1:1]};
                        if (bit_cnt == BW'(DATA_BITS - 1))
                            state <= cfg_par_en ? S_PARITY : S_STOP1;
                        else
                            bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                S_PARITY: begin
                    if (smp) begin
                        parity_err <= ((^shift) ^ rxd_s2) != cfg_par_odd;
                        state      <= S_STOP1;
                    end
                end
                S_STOP1: begin
                    if (smp) begin
                        if (!rxd_s2)
                            frame_err <= 1'b1;
                        state <= cfg_stop2 ? S_STOP2 : S_IDLE;
                    end
                end
                S_STOP2: begin
                    if (smp)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign pop       = rd_en && (count != '0);
    assign fifo_full = (count == CW'(FIFO_DEPTH));
    assign wr_ok     = push && (!fifo_full || pop);

    // FIFO storage; entries need no reset because the outputs are gated by rda.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= push_entry;
    end

    // FIFO pointers, occupancy and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (wr_ok && !pop)
                count <= count + CW'(1);
            else if (pop && !wr_ok)
                count <= count - CW'(1);
            if (pop)
                overrun <= 1'b0;
            else if (push && fifo_full)
                overrun <= 1'b1;
        end
    end

    assign rda           = (count != '0);
    assign head          = mem[rd_ptr];
    assign rd_data       = rda ? head[DATA_BITS-1:0] : '0;
    assign rd_parity_err = rda & head[DATA_BITS];
    assign rd_frame_err  = rda & head[DATA_BITS+1];

endmodule

// File: doc/spart_rx_fifo.md
# spart_rx_fifo

Parametrised SPART receive path: oversampling serial receiver with a programmable baud divisor, configurable data width, parity and stop-bit mode, and a first-word-fall-through receive FIFO that carries per-frame error flags. It replaces the fixed 8-bit receive logic inside the SPART. The driver reads it through `rd_en`/`rda` and does not need to service every frame immediately.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5..9, LSB first on the line.
- `OVERSAMPLE`, 16: ticks per bit time; even, ≥ 4.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of 2, ≥ 2.
- `DIV_W`, 16: width of `divisor`.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `rxd`  in  1  serial input; idle high; asynchronous to `clk`.
- `divisor`  in  DIV_W  clocks per oversample tick; 0 is treated as 1.
- `parity_en`  in  1  a parity bit follows the data bits.
- `parity_odd`  in  1  1 = odd parity, 0 = even; ignored when `parity_en`=0.
- `stop2`  in  1  two stop bits are checked.
- `rd_en`  in  1  pop the head entry.
- `rd_data`  out  DATA_BITS  head data; 0 when empty.
- `rd_frame_err`  out  1  head entry had a stop bit sampled 0; 0 when empty.
- `rd_parity_err`  out  1  head entry failed parity; 0 when empty.
- `rda`  out  1  FIFO not empty.
- `fifo_full`  out  1  FIFO holds FIFO_DEPTH entries.
- `overrun`  out  1  sticky: a completed frame was dropped.

## Operation
- `rxd` passes through a 2-FF synchronizer. Both flops reset to 1.
- Tick generator: a down-counter reloads with `max(divisor,1)-1` and emits a 1-clock `tick` on reaching 0. It reloads on the IDLE→START transition so the start bit is phase-aligned.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2. A tick counter in 0..OVERSAMPLE-1 tracks position within the bit.
  - IDLE: when the synchronized rxd is 0, clear the tick counter and go to START.
  - START: at tick OVERSAMPLE/2, sample. A 1 is a false start: go to IDLE with no push. A 0 goes to DATA.
  - DATA: sample every OVERSAMPLE ticks and shift in LSB first. After DATA_BITS samples go to PARITY if `parity_en`, otherwise STOP1.
  - PARITY: sample once. `parity_err` = (XOR of data bits ^ sampled bit) != `parity_odd`.
  - STOP1: sample; 0 sets `frame_err`. If `stop2`, go to STOP2; otherwise push and go to IDLE.
  - STOP2: sample; 0 sets `frame_err`. Push and go to IDLE.
- `parity_en`, `parity_odd` and `stop2` are captured on leaving IDLE. Changes mid-frame do not affect the frame in progress.
- FIFO entry format: {frame_err, parity_err, data}. Read and write pointers are log2(FIFO_DEPTH) bits wide and wrap modulo the depth. The count register is log2(FIFO_DEPTH)+1 bits.
- Push when not full: the entry is written.
- Push when full, with no pop in the same cycle: the frame is dropped and `overrun` is set.
- Push and pop in the same cycle: both take effect, including when full. Count is unchanged and no overrun occurs.
- `rd_en` while empty: ignored.
- `overrun` clears on the cycle after any accepted pop. A drop in the same cycle as a pop is impossible, per the push/pop rule.

## Timing
- Reset values: `rda`=0, `fifo_full`=0, `overrun`=0, `rd_*`=0, FSM=IDLE, pointers and count 0.
- Reset mid-frame discards the partial frame and the FIFO contents. The next falling edge after reset is received normally.
- Bit time = max(divisor,1) × OVERSAMPLE clocks. Samples fall at mid-bit.
- Latency from rxd falling to leaving IDLE: 2 synchronizer cycles + 1.
- Push happens on the clock of the final stop-bit sample, i.e. half a bit time into the last stop bit. `rda`/`rd_data` are valid the next cycle.
- Pop: `rd_en` sampled high with `rda`=1 advances the head. The new head, or `rda`=0, appears the next cycle.
- Back-to-back frames: a start edge is accepted from the first IDLE cycle. No minimum idle time is required beyond the stop bit(s).

## Test plan
- Defaults, `divisor`=5 (80 clk/bit), even parity, `stop2`=1. Send start, 0,0,1,0,1,0,1,0, parity 1, stop 1,1 → `rda`=1, `rd_data`=0x54, both error flags 0. `rd_en` pulse → `rda`=0.
- Same frame with `parity_odd`=1 → `rd_data`=0x54, `rd_parity_err`=1, `rd_frame_err`=0.
- Same frame with second stop bit driven 0 → `rd_frame_err`=1. The receiver returns to IDLE and the next frame 0xA5 reads correctly.
- rxd low for 3 ticks (15 clk), then high → no push, `rda` stays 0, FSM back in IDLE.
- Five frames 0x01..0x05 with no reads → `fifo_full`=1 after the fourth and `overrun`=1 after the fifth. Four reads return 0x01..0x04, then `rda`=0, and `overrun` clears after the first read.
- Assert `rst` during data bit 4, then send 0x3C with `parity_en`=0, `stop2`=0, DATA_BITS=8 → only 0x3C is received, no error flags.
